// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - skid FIFO holding fetched {pc, instr} pairs; flush wins over push
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Push with a simultaneous pop is fine at full; a lone push at full means the credit rule broke.
    push_when_full_a: assert property (@(posedge clk) disable iff (rst)
        !(do_push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: pc, 1-cycle memory latency tracking, redirect and halt
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'd0,
    parameter logic [PC_W-1:0] PC_LIMIT = 32'd28,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    im_pc,
    input  logic [INSTR_W-1:0] im_instruction,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [PC_W-1:0]    dec_pc,
    output logic               halted
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] inflight_pc;
    logic [PC_W-1:0] redirect_target;
    logic            inflight;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic            active;
    logic            flush;
    logic            pop;
    logic            credit_ok;
    logic            issue;

    assign active          = (state == RUN) || (state == DRAIN);
    assign flush           = active && redirect_valid;
    assign pop             = dec_valid && dec_ready;
    assign pc_inc          = pc + PC_STEP;
    assign redirect_target = word_align(redirect_pc);

    // A word already in flight holds a slot; a pop this cycle frees one, which keeps 1 instr/cycle.
    assign credit_ok = (32'(count) + 32'(inflight) - 32'(pop)) < 32'(DEPTH);
    assign issue     = (state == RUN) && credit_ok && !redirect_valid && (pc < PC_LIMIT);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = RESET_PC;
                end
            end
            RUN, DRAIN: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = (redirect_target < PC_LIMIT) ? RUN : DRAIN;
                end else if (state == RUN) begin
                    if (issue) begin
                        pc_next = pc_inc;
                        if (pc_inc >= PC_LIMIT) begin
                            state_next = DRAIN;
                        end
                    end else if (pc >= PC_LIMIT) begin
                        state_next = DRAIN;
                    end
                end else if ((count == '0) && !inflight) begin
                    state_next = HALT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
        end
    end

    assign push_data = '{pc: inflight_pc, instr: im_instruction};

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .pop       (pop),
        .flush     (flush),
        .push_data (push_data),
        .count     (count),
        .head      (head)
    );

    assign im_pc     = pc;
    assign dec_valid = (count != '0);
    assign dec_instr = dec_valid ? head.instr : '0;
    assign dec_pc    = dec_valid ? head.pc : '0;
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed table-driven bench for fetch_ctrl with a synchronous-read memory model
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_ready = 1'b0;
    logic [31:0] im_pc;
    logic [31:0] im_instruction;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        halted;

    int checks = 0;
    int failures = 0;

    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_im_pc;
        logic        exp_halted;
    } vec_t;

    vec_t t1[11];

    fetch_ctrl #(
        .RESET_PC(32'd0),
        .PC_LIMIT(32'd28),
        .DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .im_pc          (im_pc),
        .im_instruction (im_instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'd0) ? 32'h00220000 : (32'hC0DE0000 ^ a);
    endfunction

    always @(posedge clk) im_instruction <= mem_word(im_pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic collect(input int budget);
        got_pc.delete();
        got_instr.delete();
        for (int c = 0; c < budget && !halted; c++) begin
            if (dec_valid && dec_ready) begin
                got_pc.push_back(dec_pc);
                got_instr.push_back(dec_instr);
            end
            tick();
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic expect_seq(input string name);
        chk({name, "_len"}, got_pc.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_pc.size()) begin
                chk({name, "_pc"}, got_pc[i], exp_q[i]);
                chk({name, "_instr"}, got_instr[i], mem_word(exp_q[i]));
            end
        end
    endtask

    task automatic fill_linear(input int first, input int last);
        exp_q.delete();
        for (int a = first; a <= last; a += 4) exp_q.push_back(32'(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        t1[0]  = '{1'b1, 1'b0, 32'd0,  32'd0,  1'b0};
        t1[1]  = '{1'b1, 1'b0, 32'd0,  32'd4,  1'b0};
        t1[2]  = '{1'b1, 1'b1, 32'd0,  32'd8,  1'b0};
        t1[3]  = '{1'b1, 1'b1, 32'd4,  32'd12, 1'b0};
        t1[4]  = '{1'b1, 1'b1, 32'd8,  32'd16, 1'b0};
        t1[5]  = '{1'b1, 1'b1, 32'd12, 32'd20, 1'b0};
        t1[6]  = '{1'b1, 1'b1, 32'd16, 32'd24, 1'b0};
        t1[7]  = '{1'b1, 1'b1, 32'd20, 32'd28, 1'b0};
        t1[8]  = '{1'b1, 1'b1, 32'd24, 32'd28, 1'b0};
        t1[9]  = '{1'b1, 1'b0, 32'd0,  32'd28, 1'b0};
        t1[10] = '{1'b1, 1'b0, 32'd0,  32'd28, 1'b1};

        // reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_instr", dec_instr, 32'd0);
        chk("rst_pc", dec_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_im_pc", im_pc, 32'd0);
        tick();
        chk("idle_valid", {31'd0, dec_valid}, 32'd0);

        // streaming run, decode always ready
        dec_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t1_valid[%0d]", i), {31'd0, dec_valid}, {31'd0, t1[i].exp_valid});
            chk($sformatf("t1_pc[%0d]", i), dec_pc, t1[i].exp_pc);
            chk($sformatf("t1_instr[%0d]", i), dec_instr,
                t1[i].exp_valid ? mem_word(t1[i].exp_pc) : 32'd0);
            chk($sformatf("t1_im_pc[%0d]", i), im_pc, t1[i].exp_im_pc);
            chk($sformatf("t1_halted[%0d]", i), {31'd0, halted}, {31'd0, t1[i].exp_halted});
            dec_ready = t1[i].ready;
            tick();
        end

        // backpressure: FIFO fills to 2 and fetch stalls
        dec_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("bp_first_valid", {31'd0, dec_valid}, 32'd1);
        chk("bp_first_pc", dec_pc, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("bp_hold_valid[%0d]", i), {31'd0, dec_valid}, 32'd1);
            chk($sformatf("bp_hold_pc[%0d]", i), dec_pc, 32'd0);
            chk($sformatf("bp_hold_instr[%0d]", i), dec_instr, 32'h00220000);
            chk($sformatf("bp_stall_im_pc[%0d]", i), im_pc, 32'd8);
        end
        dec_ready = 1'b1;
        collect(40);
        fill_linear(0, 24);
        expect_seq("bp_seq");

        // redirect to unaligned 0x0E with two entries buffered
        dec_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("rd_pre_valid", {31'd0, dec_valid}, 32'd1);
        chk("rd_pre_pc", dec_pc, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000000E;
        tick();
        redirect_valid = 1'b0;
        chk("rd_flushed", {31'd0, dec_valid}, 32'd0);
        chk("rd_im_pc", im_pc, 32'd12);
        dec_ready = 1'b1;
        collect(40);
        exp_q = '{32'd12, 32'd16, 32'd20, 32'd24};
        expect_seq("rd_seq");

        // redirect past the limit drains straight to halt
        dec_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rl_pre_valid", {31'd0, dec_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000001C;
        tick();
        redirect_valid = 1'b0;
        chk("rl_im_pc", im_pc, 32'h1C);
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                if (dec_valid) seen++;
                tick();
            end
            chk("rl_no_valid", 32'(seen), 32'd0);
        end
        chk("rl_halted", {31'd0, halted}, 32'd1);

        // asynchronous reset between edges mid-run
        dec_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("ar_pre_valid", {31'd0, dec_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_valid", {31'd0, dec_valid}, 32'd0);
        chk("ar_im_pc", im_pc, 32'd0);
        chk("ar_halted", {31'd0, halted}, 32'd0);
        #1 rst = 1'b0;
        tick();

        // redirect is ignored in IDLE
        redirect_valid = 1'b1;
        redirect_pc = 32'h00000010;
        tick();
        tick();
        redirect_valid = 1'b0;
        chk("idle_rd_im_pc", im_pc, 32'd0);
        chk("idle_rd_valid", {31'd0, dec_valid}, 32'd0);
        chk("idle_rd_halted", {31'd0, halted}, 32'd0);
        tick();
        chk("idle_rd_still_idle", im_pc, 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ar_restart_valid", {31'd0, dec_valid}, 32'd1);
        chk("ar_restart_pc", dec_pc, 32'd0);
        collect(40);
        fill_linear(0, 24);
        expect_seq("ar_seq");

        // redirect coinciding with an issue and a pop
        dec_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rp_first_pc", dec_pc, 32'd0);
        tick();
        chk("rp_head_pc", dec_pc, 32'd4);
        chk("rp_im_pc", im_pc, 32'd12);
        redirect_valid = 1'b1;
        redirect_pc = 32'h00000010;
        tick();
        redirect_valid = 1'b0;
        chk("rp_flushed", {31'd0, dec_valid}, 32'd0);
        chk("rp_im_pc_after", im_pc, 32'd16);
        collect(40);
        exp_q = '{32'd16, 32'd20, 32'd24};
        expect_seq("rp_seq");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
